// File: rtl/alu_seq_arbiter.sv
// Two-requester round-robin front end for the nibble-serial 4-bit ALU.
// Streams op/a/b onto the ALU input, waits LATENCY cycles, captures the
// result and flags, and returns them tagged with the requester id.
module alu_seq_arbiter #(
    parameter int LATENCY = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_op,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_op,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    output logic       alu_enabled,
    output logic [3:0] alu_data,
    input  logic [3:0] alu_result,
    input  logic [3:0] alu_flags,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic [3:0] rsp_result,
    output logic [3:0] rsp_flags
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_OP   = 3'd1;
    localparam logic [2:0] S_A    = 3'd2;
    localparam logic [2:0] S_B    = 3'd3;
    localparam logic [2:0] S_WAIT = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    logic [2:0] r_state;
    logic       r_last_grant;
    logic       r_id;
    logic [3:0] r_op;
    logic [3:0] r_a;
    logic [3:0] r_b;
    logic [3:0] r_cnt;
    logic       r_rsp_id;
    logic [3:0] r_rsp_result;
    logic [3:0] r_rsp_flags;

    logic w_idle;
    logic w_gnt0;
    logic w_gnt1;

    // Grant only in IDLE and never while reset is held; on a tie the
    // requester that did not win last time gets the slot.
    assign w_idle = (r_state == S_IDLE) && !reset;
    assign w_gnt0 = w_idle && req0_valid && (!req1_valid || r_last_grant);
    assign w_gnt1 = w_idle && req1_valid && (!req0_valid || !r_last_grant);

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign rsp_valid  = (r_state == S_DONE);
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_flags  = r_rsp_flags;

    // Sequencer: latch the winner, stream three nibbles, wait, capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_op         <= 4'h0;
            r_a          <= 4'h0;
            r_b          <= 4'h0;
            r_cnt        <= 4'h0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= 4'h0;
            r_rsp_flags  <= 4'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        r_id         <= w_gnt1;
                        r_last_grant <= w_gnt1;
                        r_op         <= w_gnt1 ? req1_op : req0_op;
                        r_a          <= w_gnt1 ? req1_a  : req0_a;
                        r_b          <= w_gnt1 ? req1_b  : req0_b;
                        r_state      <= S_OP;
                    end
                end
                S_OP: r_state <= S_A;
                S_A:  r_state <= S_B;
                S_B: begin
                    r_cnt   <= LAT_M1;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == 4'h0) begin
                        r_rsp_id     <= r_id;
                        r_rsp_result <= alu_result;
                        r_rsp_flags  <= alu_flags;
                        r_state      <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'h1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ALU input stream: only the three streaming states drive the port.
    always_comb begin
        alu_enabled = 1'b0;
        alu_data    = 4'h0;
        case (r_state)
            S_OP: begin alu_enabled = 1'b1; alu_data = r_op; end
            S_A:  begin alu_enabled = 1'b1; alu_data = r_a;  end
            S_B:  begin alu_enabled = 1'b1; alu_data = r_b;  end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_seq_arbiter.sv
// Bench for alu_seq_arbiter: transaction-level model plus directed pins.
module tb_alu_seq_arbiter;

    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [3:0] req0_op, req0_a, req0_b, req1_op, req1_a, req1_b;
    logic       alu_enabled;
    logic [3:0] alu_data, alu_result, alu_flags;
    logic       rsp_valid, rsp_id;
    logic [3:0] rsp_result, rsp_flags;

    // second instance built with a longer result latency
    logic       reset5, v5;
    logic       rdy0_5, rdy1_5, en5, rv5, rid5;
    logic [3:0] dat5, res5_in, flg5_in, res5, flg5;

    always #5 clk = ~clk;

    alu_seq_arbiter u_dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .alu_enabled(alu_enabled), .alu_data(alu_data),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags)
    );

    alu_seq_arbiter #(.LATENCY(5)) u_dut5 (
        .clk(clk), .reset(reset5),
        .req0_valid(v5), .req0_ready(rdy0_5),
        .req0_op(4'h2), .req0_a(4'h4), .req0_b(4'h6),
        .req1_valid(1'b0), .req1_ready(rdy1_5),
        .req1_op(4'h0), .req1_a(4'h0), .req1_b(4'h0),
        .alu_enabled(en5), .alu_data(dat5),
        .alu_result(res5_in), .alu_flags(flg5_in),
        .rsp_valid(rv5), .rsp_id(rid5),
        .rsp_result(res5), .rsp_flags(flg5)
    );

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, act, exp);
        end
    endtask

    // Reference ALU behaviour used by the bench's ALU stand-in.
    task automatic alu_fn(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                          output logic [3:0] r, output logic [3:0] f);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b};
        r = s[3:0] ^ (op - 4'd1);
        f = {s[4], r == 4'h0, op[3:2]};
    endtask

    // Transaction model: one outstanding op, described by its transfer cycle.
    int         cyc = 0;
    bit         m_busy = 0;
    int         m_t0 = 0;
    bit         m_id = 0;
    bit         m_last = 1;
    logic [3:0] m_op = 0, m_a = 0, m_b = 0;
    bit         h_id = 0;
    logic [3:0] h_res = 0, h_flg = 0;

    // One clock cycle: drive ALU stand-in, compare every output, advance model.
    task automatic tick();
        int k;
        logic e_r0, e_r1, e_en, e_rv;
        logic [3:0] e_d, fr, ff;
        k = cyc - m_t0;
        if (m_busy && k >= 5 + LAT) m_busy = 0;
        alu_fn(m_op, m_a, m_b, fr, ff);
        if (m_busy && k == 3 + LAT) begin
            alu_result = fr;
            alu_flags  = ff;
        end else begin
            alu_result = fr ^ 4'($urandom_range(1, 15));
            alu_flags  = ff ^ 4'($urandom_range(1, 15));
        end
        e_r0 = 0;
        e_r1 = 0;
        if (!m_busy && !reset) begin
            if (req0_valid && req1_valid) begin
                e_r0 = m_last;
                e_r1 = !m_last;
            end else begin
                e_r0 = req0_valid;
                e_r1 = req1_valid;
            end
        end
        e_en = m_busy && k >= 1 && k <= 3;
        e_d  = !e_en ? 4'h0 : (k == 1) ? m_op : (k == 2) ? m_a : m_b;
        e_rv = m_busy && k == 4 + LAT;
        #1;
        chk("req0_ready", req0_ready, e_r0);
        chk("req1_ready", req1_ready, e_r1);
        chk("alu_enabled", alu_enabled, e_en);
        chk("alu_data", alu_data, e_d);
        chk("rsp_valid", rsp_valid, e_rv);
        chk("rsp_id", rsp_id, h_id);
        chk("rsp_result", rsp_result, h_res);
        chk("rsp_flags", rsp_flags, h_flg);
        if (reset) begin
            m_busy = 0; m_last = 1; h_id = 0; h_res = 0; h_flg = 0;
        end else begin
            if (m_busy && k == 3 + LAT) begin
                h_id = m_id; h_res = fr; h_flg = ff;
            end
            if (e_r0 || e_r1) begin
                m_busy = 1; m_t0 = cyc; m_id = e_r1; m_last = e_r1;
                m_op = e_r1 ? req1_op : req0_op;
                m_a  = e_r1 ? req1_a  : req0_a;
                m_b  = e_r1 ? req1_b  : req0_b;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1; req0_valid = 0; req1_valid = 0;
        tick();
        reset = 0;
    endtask

    int gcyc[$];
    int gid[$];
    int rids[$];

    initial begin
        reset = 1; req0_valid = 0; req1_valid = 0;
        req0_op = 0; req0_a = 0; req0_b = 0; req1_op = 0; req1_a = 0; req1_b = 0;
        alu_result = 0; alu_flags = 0;
        reset5 = 1; v5 = 0; res5_in = 0; flg5_in = 0;
        @(posedge clk);
        #1;
        do_reset();   // checked reset-state cycle

        // single op from requester 0: literal pins
        req0_valid = 1; req0_op = 4'h1; req0_a = 4'h3; req0_b = 4'h5;
        #1;
        chk("t1_ready0", req0_ready, 1);
        tick();
        req0_valid = 0;
        for (int i = 1; i <= 6; i++) begin
            #1;
            if (i <= 3) begin
                chk("t1_alu_en", alu_enabled, 1);
                chk("t1_alu_data", alu_data, (i == 1) ? 4'h1 : (i == 2) ? 4'h3 : 4'h5);
            end
            if (i == 6) begin
                chk("t1_rsp_valid", rsp_valid, 1);
                chk("t1_rsp_id", rsp_id, 0);
                chk("t1_rsp_result", rsp_result, 4'h8);
                chk("t1_rsp_flags", rsp_flags, 4'h0);
            end
            tick();
        end

        // tie from reset: grants alternate, 7 cycles apart
        do_reset();
        req0_valid = 1; req1_valid = 1;
        for (int i = 0; i < 28; i++) begin
            req0_op = 4'($urandom); req0_a = 4'($urandom); req0_b = 4'($urandom);
            req1_op = 4'($urandom); req1_a = 4'($urandom); req1_b = 4'($urandom);
            #1;
            if (req0_ready || req1_ready) begin
                gcyc.push_back(i);
                gid.push_back(int'(req1_ready));
            end
            if (rsp_valid) rids.push_back(int'(rsp_id));
            tick();
        end
        chk("t2_grants", gcyc.size(), 4);
        chk("t2_rsps", rids.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < gcyc.size()) begin
                chk("t2_gcyc", gcyc[i], i * 7);
                chk("t2_gid", gid[i], i % 2);
            end
            if (i < rids.size()) chk("t2_rsp_id", rids[i], i % 2);
        end

        // randomized segments: mixed, req1 only, heavy tie, sparse + resets
        for (int seg = 0; seg < 4; seg++) begin
            for (int i = 0; i < 150; i++) begin
                reset = ($urandom_range(0, 59) == 0);
                case (seg)
                    0: begin req0_valid = $urandom_range(0, 1); req1_valid = $urandom_range(0, 1); end
                    1: begin req0_valid = 0; req1_valid = 1; end
                    2: begin req0_valid = $urandom_range(0, 4) != 0; req1_valid = $urandom_range(0, 4) != 0; end
                    default: begin req0_valid = $urandom_range(0, 5) == 0; req1_valid = $urandom_range(0, 5) == 0; end
                endcase
                req0_op = 4'($urandom); req0_a = 4'($urandom); req0_b = 4'($urandom);
                req1_op = 4'($urandom); req1_a = 4'($urandom); req1_b = 4'($urandom);
                tick();
            end
        end
        reset = 0; req0_valid = 0; req1_valid = 0;
        for (int i = 0; i < 10; i++) tick();

        // LATENCY=5 instance: response at T+9, next grant at T+10
        reset5 = 1;
        @(posedge clk);
        #1;
        reset5 = 0; v5 = 1;
        for (int k = 0; k <= 10; k++) begin
            res5_in = (k == 8) ? 4'hA : 4'h0;
            flg5_in = (k == 8) ? 4'h3 : 4'h0;
            #1;
            chk("t4_ready0", rdy0_5, (k == 0 || k == 10));
            chk("t4_ready1", rdy1_5, 0);
            chk("t4_rsp_valid", rv5, (k == 9));
            if (k == 9) begin
                chk("t4_rsp_result", res5, 4'hA);
                chk("t4_rsp_flags", flg5, 4'h3);
            end
            @(posedge clk);
            #1;
        end
        v5 = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq_arbiter.md
# alu_seq_arbiter

Front-end controller for the 4-bit sequential ALU (`dsp_4bits_seq_alu`). It lets two independent requesters share the ALU's single nibble-serial input port. It arbitrates round-robin between them and serialises the winner's opcode, operand A and operand B onto the ALU input stream. It waits a fixed result latency, captures the ALU result and flags, and returns them on a shared response channel tagged with the requester id.

## Interface

Parameters:
- `LATENCY`, default 2: ALU cycles from the last operand nibble to a valid result/flags. Legal range 1..15.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has an operation pending.
- `req0_ready`  out  1  requester 0 accepted this cycle.
- `req0_op`  in  4  requester 0 opcode nibble.
- `req0_a`  in  4  requester 0 operand A.
- `req0_b`  in  4  requester 0 operand B.
- `req1_valid`, `req1_ready`, `req1_op`, `req1_a`, `req1_b`: same as requester 0, for requester 1.
- `alu_enabled`  out  1  drives the ALU `enabled` input; high while nibbles are streamed.
- `alu_data`  out  4  drives the ALU `data` nibble.
- `alu_result`  in  4  ALU result nibble (ALU `io_out[3:0]`).
- `alu_flags`  in  4  ALU flags nibble (ALU `io_out[7:4]`).
- `rsp_valid`  out  1  one-cycle pulse; the response fields are valid.
- `rsp_id`  out  1  requester that owns the response.
- `rsp_result`  out  4  captured result.
- `rsp_flags`  out  4  captured flags.

## Operation

- States: IDLE, OP, A, B, WAIT, DONE.
- **IDLE**
  - `alu_enabled`=0 and `alu_data`=0.
  - If either `valid` is high, the arbiter grants one requester, and `reqN_ready` is driven high combinationally in that cycle.
  - A transfer occurs when `valid` and `ready` are both high.
  - On transfer: op, a and b are latched into internal registers, the granted id is latched, and the FSM moves to OP.
  - Requester inputs are not used after the transfer cycle.
- **Arbitration**
  - A `last_grant` register holds the most recently granted id.
  - If only one requester is valid, it is granted.
  - If both are valid, the requester that is not `last_grant` is granted.
  - `last_grant` updates on every transfer.
  - Reset value of `last_grant` is 1, so requester 0 wins the first tie.
  - `ready` is never high for both requesters in the same cycle.
  - `ready` is never high outside IDLE.
- **OP / A / B**
  - `alu_enabled`=1 in all three states.
  - `alu_data` = latched op in OP, latched a in A, latched b in B.
  - Each state lasts exactly 1 cycle. Sequence is OP→A→B→WAIT.
- **WAIT**
  - `alu_enabled`=0 and `alu_data`=0.
  - A 4-bit down-counter is loaded with `LATENCY`-1 on entry and decrements each cycle.
  - When the counter is 0, `alu_result` and `alu_flags` are registered into `rsp_result`/`rsp_flags` at the clock edge, and the FSM moves to DONE.
  - WAIT therefore lasts exactly `LATENCY` cycles.
- **DONE**
  - `rsp_valid`=1 for exactly one cycle, and `rsp_id` = latched id. Next state is IDLE.
  - There is no response back-pressure; the requester must sample `rsp_*` in the DONE cycle.
- `rsp_result`, `rsp_flags` and `rsp_id` hold their last values until the next capture.
- Response ordering: there is exactly one outstanding operation at a time, so responses are in grant order.

## Timing

- Reset values:
  - FSM in IDLE.
  - `req0_ready`/`req1_ready` are 0 while `reset` is high.
  - `alu_enabled`=0, `alu_data`=0.
  - `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_flags`=0.
  - `last_grant`=1 and the counter is 0.
- Transfer at cycle T gives:
  - OP at T+1, A at T+2, B at T+3.
  - WAIT from T+4 to T+3+`LATENCY`.
  - DONE at T+4+`LATENCY`.
  - IDLE again at T+5+`LATENCY`.
- The earliest next transfer is T+5+`LATENCY`. With default `LATENCY`=2, that is one operation per 7 cycles.
- Reset mid-operation (any non-IDLE state):
  - The in-flight operation is discarded and no `rsp_valid` is produced for it.
  - All outputs take their reset values in the cycle after the reset edge.
  - Arbitration restarts with requester 0 favoured.
- A requester dropping `valid` before being granted is legal; nothing is latched for it.
- The `valid` inputs are ignored in every state other than IDLE.

## Test plan

1. **Single op.** Reset, then `req0`: op=0x1, a=0x3, b=0x5, ALU model returns result=0x8, flags=0x0 after 2 cycles.
   - Required: `req0_ready` at T.
   - `alu_data` = 1, 3, 5 with `alu_enabled`=1 at T+1..T+3.
   - `rsp_valid` at T+6 with id=0, result=0x8, flags=0x0.
2. **Tie and alternation.** Both requesters valid continuously from reset.
   - Required grant order is 0,1,0,1.
   - Transfers are spaced exactly 7 cycles apart.
   - `rsp_id` alternates 0,1,0,1.
3. **Single requester back-to-back.** Only `req1` valid for 3 operations.
   - Required: `req1` is granted every 7 cycles; `req0_ready` stays 0.
4. **Latency parameter.** Build with `LATENCY`=5; ALU model presents result=0xA, flags=0x3 only after 5 cycles.
   - Required: `rsp_valid` at T+9 with 0xA/0x3.
   - Neither requester is granted before T+10.
5. **Reset mid-op.** Assert `reset` for one cycle during the A state.
   - Required: outputs return to reset values.
   - No `rsp_valid` for the aborted operation.
   - The next tie grants `req0`.
6. **Withdrawn request.** `req1_valid` pulses for one cycle while the FSM is in WAIT.
   - Required: no `req1_ready`, and no extra ALU traffic after DONE.
